aes_word_stream_adapter: RTL and testbench

Streaming front/back end for the AES-256 core. It accepts 32-bit words on a valid/ready input port and packs them into a 128-bit block. It then drives the core's data, enable and mode inputs, waits for the core's `done`, and captures the result. Finally it unpacks the result into 32-bit words on a valid/ready output port. It sits directly between the system bus/DMA and the AES-256 core, and owns the core's `En` and `encryp_decrypt` lines.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_block_shreg.sv | 50 +++++
 rtl/aes_word_stream_adapter.sv | 169 ++++++++++++++++
 tb/tb_aes_word_stream_adapter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and sizing for the AES word-stream adapter: FSM states,
// default widths, block word count and counter width.
package aes_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WORD_WIDTH_DEFAULT     = 32;
  localparam int DATA_WIDTH_DEFAULT     = 128;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
  localparam int WORDS_PER_BLOCK        = DATA_WIDTH_DEFAULT / WORD_WIDTH_DEFAULT;
  localparam int CNT_W                  = $clog2(WORDS_PER_BLOCK);

  function automatic int words_per_block(input int data_width, input int word_width);
    return data_width / word_width;
  endfunction

endpackage

// File: rtl/aes_block_shreg.sv
// Word-wide shift register with parallel load. Shifting moves every word one
// slot toward the MSB end and inserts shift_in at the LSB word.
module aes_block_shreg
  import aes_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] shift_in,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int WPB = words_per_block(DATA_WIDTH, WORD_WIDTH);

  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_next;

  genvar gi;
  generate
    for (gi = 0; gi < WPB; gi++) begin : g_word
      logic [WORD_WIDTH-1:0] shifted;
      if (gi == 0) begin : g_lsw
        assign shifted = shift_in;
      end else begin : g_upper
        assign shifted = data_reg[(gi-1)*WORD_WIDTH +: WORD_WIDTH];
      end
      // Parallel load wins over shift; the two are never requested together.
      assign data_next[gi*WORD_WIDTH +: WORD_WIDTH] =
        load  ? load_data[gi*WORD_WIDTH +: WORD_WIDTH] :
        shift ? shifted :
                data_reg[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/aes_word_stream_adapter.sv
// Packs stream words into an AES block, runs the core until done (or timeout),
// then unpacks the result onto the output stream. Half-duplex by state.
module aes_word_stream_adapter
  import aes_pkg::*;
#(
  parameter int WORD_WIDTH     = WORD_WIDTH_DEFAULT,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  core_en,
  output logic                  core_mode,
  output logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int WPB = words_per_block(DATA_WIDTH, WORD_WIDTH);
  localparam int CW  = $clog2(WPB);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state_reg;
  logic [CW-1:0]   word_cnt_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            out_last_reg;
  logic            core_en_reg;
  logic            core_mode_reg;
  logic            busy_reg;
  logic            timeout_err_reg;

  logic [DATA_WIDTH-1:0] out_block;
  logic                  in_fire;
  logic                  out_fire;
  logic                  done_ok;
  logic                  last_word;
  logic                  unused_out_low;

  assign in_fire   = in_valid & in_ready_reg;
  assign out_fire  = out_valid_reg & out_ready;
  assign last_word = (word_cnt_reg == CW'(WPB - 1));
  // done may still be high from the previous block in the first RUN cycle;
  // once the abort pulse is up the block is already committed to discard.
  assign done_ok   = (state_reg == RUN) && (tmo_cnt_reg != '0) && core_done && !timeout_err_reg;

  aes_block_shreg #(
    .WORD_WIDTH (WORD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_in_pack (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_fire),
    .shift_in  (in_data),
    .data      (core_data_in)
  );

  aes_block_shreg #(
    .WORD_WIDTH (WORD_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_unpack (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (done_ok),
    .load_data (core_data_out),
    .shift     (out_fire),
    .shift_in  ('0),
    .data      (out_block)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg       <= FILL;
      word_cnt_reg    <= '0;
      tmo_cnt_reg     <= '0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      core_en_reg     <= 1'b0;
      core_mode_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        FILL: begin
          if (in_fire) begin
            if (word_cnt_reg == '0) begin
              core_mode_reg <= in_mode;
            end
            if (last_word) begin
              word_cnt_reg <= '0;
              tmo_cnt_reg  <= '0;
              state_reg    <= RUN;
              in_ready_reg <= 1'b0;
              core_en_reg  <= 1'b1;
              busy_reg     <= 1'b1;
            end else begin
              word_cnt_reg <= word_cnt_reg + CW'(1);
            end
          end
        end

        RUN: begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          if (timeout_err_reg) begin
            timeout_err_reg <= 1'b0;
            state_reg       <= FILL;
            core_en_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            in_ready_reg    <= 1'b1;
          end else if (done_ok) begin
            state_reg     <= DRAIN;
            core_en_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            out_last_reg  <= 1'b0;
            word_cnt_reg  <= '0;
          end else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 2)) begin
            // Raised one cycle early so the pulse lands on the final RUN cycle.
            timeout_err_reg <= 1'b1;
          end
        end

        DRAIN: begin
          if (out_fire) begin
            if (last_word) begin
              word_cnt_reg  <= '0;
              state_reg     <= FILL;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              busy_reg      <= 1'b0;
              in_ready_reg  <= 1'b1;
            end else begin
              word_cnt_reg <= word_cnt_reg + CW'(1);
              out_last_reg <= (word_cnt_reg == CW'(WPB - 2));
            end
          end
        end

        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_reg;
  assign out_valid      = out_valid_reg;
  assign out_last       = out_last_reg;
  assign out_data       = out_block[DATA_WIDTH-1 -: WORD_WIDTH];
  assign core_en        = core_en_reg;
  assign core_mode      = core_mode_reg;
  assign busy           = busy_reg;
  assign timeout_err    = timeout_err_reg;
  assign unused_out_low = ^out_block[DATA_WIDTH-WORD_WIDTH-1:0];

endmodule

// File: tb/tb_aes_word_stream_adapter.sv
// Bench for aes_word_stream_adapter: a stub AES core (FIPS-197 AES-256 vector
// plus an invertible scramble for other blocks) and a block-level reference model.
module tb_aes_word_stream_adapter;

  localparam int WW = 32;
  localparam int DW = 128;
  localparam int TO = 16;

  localparam logic [DW-1:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [DW-1:0] MASK = 128'h5a3c96e1_0f1e2d3c_4b5a6978_8796a5b4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          core_en;
  logic          core_mode;
  logic [DW-1:0] core_data_in;
  logic          core_done;
  logic [DW-1:0] core_data_out;
  logic          busy;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  aes_word_stream_adapter #(
    .WORD_WIDTH     (WW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_mode       (in_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .core_en       (core_en),
    .core_mode     (core_mode),
    .core_data_in  (core_data_in),
    .core_done     (core_done),
    .core_data_out (core_data_out),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  // Core behaviour: the FIPS-197 AES-256 pair, otherwise an invertible scramble.
  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] d, input logic enc);
    logic [DW-1:0] x;
    if (enc) begin
      if (d == PT) return CT;
      return {d[DW-9:0], d[DW-1 -: 8]} ^ MASK;
    end
    if (d == CT) return PT;
    x = d ^ MASK;
    return {x[7:0], x[DW-1:8]};
  endfunction

  // Stub core: latches inputs on the En rising edge, raises done after
  // stub_lat+1 cycles and keeps it high (stale) until the next En edge.
  logic    stub_dead;
  int      stub_lat;
  logic    en_prev;
  logic    stub_busy;
  int      stub_cnt;
  logic [DW-1:0] lat_in;
  logic    lat_mode;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      en_prev       <= 1'b0;
      stub_busy     <= 1'b0;
      stub_cnt      <= 0;
      core_done     <= 1'b0;
      core_data_out <= '0;
      lat_in        <= '0;
      lat_mode      <= 1'b0;
    end else begin
      en_prev <= core_en;
      if (core_en && !en_prev) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat;
        core_done <= 1'b0;
        lat_in    <= core_data_in;
        lat_mode  <= core_mode;
      end else if (stub_busy) begin
        if (stub_cnt == 0) begin
          stub_busy     <= 1'b0;
          core_done     <= !stub_dead;
          core_data_out <= core_fn(lat_in, lat_mode);
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  // Reference model: word 0 is the MSB word, mode comes from word 0 only.
  function automatic void model_block(input logic [WW-1:0] w[4], input logic m[4],
                                      output logic [WW-1:0] e[4]);
    logic [DW-1:0] blk;
    logic [DW-1:0] res;
    blk = {w[0], w[1], w[2], w[3]};
    res = core_fn(blk, m[0]);
    for (int i = 0; i < 4; i++) e[i] = res[DW-1-WW*i -: WW];
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_words(input logic [WW-1:0] w[4], input logic m[4], input bit gaps,
                            output int t);
    int guard;
    t = -1;
    for (int i = 0; i < 4; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_mode  = 1'($urandom_range(0, 1));
        step();
      end
      in_valid = 1'b1;
      in_data  = w[i];
      in_mode  = m[i];
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
        step();
        guard++;
      end
      if (guard >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_wait: got in_ready=%b expected 1 within 50 cycles", in_ready);
        in_valid = 1'b0;
        return;
      end
      t = cyc;
      step();
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic run_block(input logic [WW-1:0] w[4], input logic m[4], input int lat,
                           input int stall_word, input int stall_len, input bit rnd,
                           input string tag);
    logic [WW-1:0] e[4];
    int t;
    int guard;
    int tmo_seen;
    int s;
    model_block(w, m, e);
    stub_lat = lat;
    send_words(w, m, rnd, t);
    if (t < 0) return;
    n_checks++;
    if (core_en !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s run_entry: got en/ready/busy=%b%b%b expected 101", tag, core_en, in_ready, busy);
    end
    n_checks++;
    if (core_data_in !== {w[0], w[1], w[2], w[3]} || core_mode !== m[0]) begin
      n_fail++;
      $display("FAIL %s core_inputs: got %h mode %b expected %h mode %b", tag, core_data_in,
               core_mode, {w[0], w[1], w[2], w[3]}, m[0]);
    end
    guard = 0;
    tmo_seen = 0;
    while (out_valid !== 1'b1 && guard < TO + 6) begin
      if (timeout_err === 1'b1) tmo_seen++;
      step();
      guard++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || cyc != t + lat + 4) begin
      n_fail++;
      $display("FAIL %s drain_entry: got out_valid=%b at cycle t+%0d expected 1 at t+%0d", tag,
               out_valid, cyc - t, lat + 4);
      if (out_valid !== 1'b1) return;
    end
    n_checks++;
    if (tmo_seen != 0) begin
      n_fail++;
      $display("FAIL %s no_timeout: got %0d timeout pulses expected 0", tag, tmo_seen);
    end
    for (int k = 0; k < 4; k++) begin
      s = rnd ? $urandom_range(0, 2) : ((k == stall_word) ? stall_len : 0);
      out_ready = 1'b0;
      for (int j = 0; j < s; j++) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== e[k]) begin
          n_fail++;
          $display("FAIL %s hold%0d: got valid=%b data=%h expected valid=1 data=%h", tag, k,
                   out_valid, out_data, e[k]);
        end
        step();
      end
      out_ready = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e[k]) begin
        n_fail++;
        $display("FAIL %s word%0d: got valid=%b data=%h expected valid=1 data=%h", tag, k,
                 out_valid, out_data, e[k]);
      end
      n_checks++;
      if (out_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL %s last%0d: got %b expected %b", tag, k, out_last, (k == 3));
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s fill_return: got ready/valid/busy=%b%b%b expected 100", tag, in_ready,
               out_valid, busy);
    end
    $display("block %s: in=%h mode=%b out=%h%h%h%h lat=%0d", tag, {w[0], w[1], w[2], w[3]},
             m[0], e[0], e[1], e[2], e[3], lat);
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handshake: got ready/valid/last/busy=%b%b%b%b expected 1000", tag,
               in_ready, out_valid, out_last, busy);
    end
    n_checks++;
    if (core_en !== 1'b0 || core_mode !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ctrl: got en/mode/tmo=%b%b%b expected 000", tag, core_en, core_mode,
               timeout_err);
    end
    n_checks++;
    if (core_data_in !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL %s data: got core_data_in=%h out_data=%h expected zero", tag,
               core_data_in, out_data);
    end
  endtask

  logic [WW-1:0] pt_w[4];
  logic [WW-1:0] ct_w[4];
  logic          enc_m[4];
  logic          dec_m[4];
  logic          mix_m[4];

  task automatic test_reset();
    Rst = 1'b1;
    #3;
    check_idle_outputs("reset");
    step();
    step();
    @(negedge Clk);
    Rst = 1'b0;
    step();
  endtask

  task automatic test_encrypt_vector();
    run_block(pt_w, enc_m, 3, 0, 0, 1'b0, "encrypt");
  endtask

  task automatic test_decrypt_vector();
    run_block(ct_w, dec_m, 5, 0, 0, 1'b0, "decrypt");
  endtask

  task automatic test_backpressure();
    run_block(pt_w, enc_m, 2, 2, 5, 1'b0, "backpressure");
  endtask

  task automatic test_mode_change();
    run_block(pt_w, mix_m, 4, 0, 0, 1'b0, "mode_change");
  endtask

  task automatic test_timeout();
    int t;
    int tmo_count;
    int tmo_cyc;
    bit ov_seen;
    logic fill_ok;
    stub_dead = 1'b1;
    stub_lat  = 0;
    send_words(pt_w, enc_m, 1'b0, t);
    tmo_count = 0;
    tmo_cyc   = -1;
    ov_seen   = 1'b0;
    fill_ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (timeout_err === 1'b1) begin
        tmo_count++;
        tmo_cyc = cyc;
      end
      if (out_valid === 1'b1) ov_seen = 1'b1;
      if (cyc == t + TO + 1) fill_ok = in_ready;
      step();
    end
    n_checks++;
    if (tmo_count != 1 || tmo_cyc != t + TO) begin
      n_fail++;
      $display("FAIL timeout pulse: got %0d pulses at t+%0d expected 1 at t+%0d", tmo_count,
               tmo_cyc - t, TO);
    end
    n_checks++;
    if (ov_seen || fill_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout abort: got out_valid_seen=%b in_ready_after=%b expected 0 and 1",
               ov_seen, fill_ok);
    end
    $display("timeout block: pulses=%0d at t+%0d", tmo_count, tmo_cyc - t);
    stub_dead = 1'b0;
    run_block(ct_w, dec_m, 1, 0, 0, 1'b0, "after_timeout");
  endtask

  task automatic test_reset_mid_run();
    int t;
    stub_lat = 8;
    send_words(pt_w, enc_m, 1'b0, t);
    step();
    step();
    #2;
    Rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_run");
    $display("reset mid-run at cycle t+%0d", cyc - t);
    @(negedge Clk);
    Rst = 1'b0;
    step();
    run_block(ct_w, dec_m, 6, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w[4];
    logic          m[4];
    int            lat;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) begin
        w[i] = $urandom;
        m[i] = 1'($urandom_range(0, 1));
      end
      lat = (b == 3) ? TO - 4 : (b == 5) ? 0 : $urandom_range(0, TO - 4);
      run_block(w, m, lat, 0, 0, 1'b1, $sformatf("rand%0d", b));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pt_w  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    ct_w  = '{32'h8ea2b7ca, 32'h516745bf, 32'heafc4990, 32'h4b496089};
    enc_m = '{1'b1, 1'b1, 1'b1, 1'b1};
    dec_m = '{1'b0, 1'b0, 1'b0, 1'b0};
    mix_m = '{1'b1, 1'b0, 1'b0, 1'b0};
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    stub_dead = 1'b0;
    stub_lat  = 0;

    test_reset();
    test_encrypt_vector();
    test_decrypt_vector();
    test_backpressure();
    test_mode_change();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
